// File: rtl/mem_pkg.sv
// Shared definitions for the RAM request sequencer: access-size encodings,
// sequencer states, default address width and read-data zero extension.
package mem_pkg;

   localparam int MEM_ADDR_W = 8;

   localparam logic [1:0] WS_BYTE  = 2'b00;
   localparam logic [1:0] WS_HALF  = 2'b01;
   localparam logic [1:0] WS_WORD  = 2'b10;
   localparam logic [1:0] WS_DWORD = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   // Zero-extend a single-beat read to 64 bits according to its size.
   function automatic logic [63:0] zext(input logic [1:0] ws, input logic [31:0] d);
      case (ws)
         WS_BYTE: return {56'd0, d[7:0]};
         WS_HALF: return {48'd0, d[15:0]};
         WS_WORD: return {32'd0, d};
         default: return {32'd0, d};
      endcase
   endfunction

endpackage

// File: rtl/mac_timeout_ctr.sv
// Per-beat Moc wait counter. Cleared outside the wait state, counts every
// enabled edge; 'expired' flags the enabled edge on which the count reaches MAX.
module mac_timeout_ctr #(
   parameter int W   = 8,
   parameter int MAX = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [W-1:0] LIM = W'(MAX);

   logic [W-1:0] cnt;
   logic [W-1:0] cnt_nxt;

   assign cnt_nxt = cnt + W'(1);
   assign expired = en && (cnt_nxt == LIM);

   // Count wait edges; clear has priority so each beat starts from zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en)  cnt <= cnt_nxt;
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Request sequencer in front of the 256x8 RAM. Accepts b/h/w/dw requests,
// drives Mov/RW/ws/Address/DataIn, waits for Moc with a per-beat timeout and
// splits doublewords into two 32-bit beats (high half first, same address).
// Build option MEM_WRITE_POSTED_EN: write beats complete on the edge after
// the blank edge without waiting for Moc, so writes can never time out.
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_W  = MEM_ADDR_W,
   parameter int TIMEOUT = 15
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              ReqValid,
   output logic              ReqReady,
   input  logic              ReqRW,
   input  logic [1:0]        ReqWs,
   input  logic [ADDR_W-1:0] ReqAddr,
   input  logic [63:0]       ReqData,
   output logic              RspValid,
   output logic [63:0]       RspData,
   output logic              RspErr,
   output logic              Mov,
   output logic              RW,
   output logic [1:0]        Ws,
   output logic [ADDR_W-1:0] Address,
   output logic [31:0]       MemDataIn,
   input  logic [31:0]       MemDataOut,
   input  logic              Moc
);

   state_t      state;
   logic [31:0] data_lo;   // low half of a doubleword, sent on beat 1
   logic        beat;      // 0 = first beat, 1 = second doubleword beat
   logic        blank;     // first wait edge after Mov rises ignores Moc
   logic        posted;
   logic        done;
   logic        tmo_exp;

`ifdef MEM_WRITE_POSTED_EN
   assign posted = ~RW;
`else
   assign posted = 1'b0;
`endif

   assign ReqReady = (state == S_IDLE);
   assign done     = ~blank & (Moc | posted);

   mac_timeout_ctr #(.W(8), .MAX(TIMEOUT)) u_tmo (
      .clk     (Clk),
      .rst     (Reset),
      .clr     (state != S_WAIT),
      .en      (state == S_WAIT),
      .expired (tmo_exp)
   );

   // Sequencer: accept, wait for Moc per beat, insert the Mov-low gap, respond.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= S_IDLE;
         Mov       <= 1'b0;
         RW        <= 1'b0;
         Ws        <= 2'b00;
         Address   <= '0;
         MemDataIn <= '0;
         RspValid  <= 1'b0;
         RspData   <= '0;
         RspErr    <= 1'b0;
         beat      <= 1'b0;
         blank     <= 1'b0;
         data_lo   <= '0;
      end else begin
         RspValid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ReqValid) begin
                  Mov       <= 1'b1;
                  RW        <= ReqRW;
                  Ws        <= ReqWs;
                  Address   <= ReqAddr;
                  MemDataIn <= (ReqWs == WS_DWORD) ? ReqData[63:32] : ReqData[31:0];
                  data_lo   <= ReqData[31:0];
                  beat      <= 1'b0;
                  blank     <= 1'b1;
                  state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               blank <= 1'b0;
               if (done) begin
                  Mov <= 1'b0;
                  if (Ws == WS_DWORD && !beat) begin
                     RspData[63:32] <= MemDataOut;
                     state          <= S_GAP;
                  end else begin
                     RspValid <= 1'b1;
                     RspErr   <= 1'b0;
                     if (!RW)
                        RspData <= '0;
                     else if (Ws == WS_DWORD)
                        RspData[31:0] <= MemDataOut;
                     else
                        RspData <= zext(Ws, MemDataOut);
                     state <= S_IDLE;
                  end
               end else if (tmo_exp && !posted) begin
                  Mov      <= 1'b0;
                  RspValid <= 1'b1;
                  RspErr   <= 1'b1;
                  RspData  <= '0;
                  state    <= S_IDLE;
               end
            end
            S_GAP: begin
               beat      <= 1'b1;
               MemDataIn <= data_lo;
               Mov       <= 1'b1;
               blank     <= 1'b1;
               state     <= S_WAIT;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
